// File: rtl/vga_rx.sv
// VGA capture: recovers pixel timing from sync inputs, acquires lock, emits active pixels with coordinates.
// Latency 2 clk from pins to pix_valid; free-running with no backpressure, so outputs are strobes.
module vga_rx #(
    parameter int PIXEL_BITS  = 4,
    parameter int CLK_DIV     = 2,
    parameter int H_COUNT_MAX = 800,
    parameter int V_COUNT_MAX = 525,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PIXEL_BITS-1:0]           vga_r,
    input  logic [PIXEL_BITS-1:0]           vga_g,
    input  logic [PIXEL_BITS-1:0]           vga_b,
    input  logic                            h_sync,
    input  logic                            v_sync,
    output logic [3*PIXEL_BITS-1:0]         pix_data,
    output logic [$clog2(H_COUNT_MAX)-1:0]  pix_x,
    output logic [$clog2(V_COUNT_MAX)-1:0]  pix_y,
    output logic                            pix_valid,
    output logic                            frame_start,
    output logic                            line_err,
    output logic                            frame_err,
    output logic                            locked
);
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int HW = $clog2(H_COUNT_MAX + 1);
    localparam int VW = $clog2(V_COUNT_MAX + 1);
    localparam int XW = $clog2(H_COUNT_MAX);
    localparam int YW = $clog2(V_COUNT_MAX);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_MAX_C   = HW'(H_COUNT_MAX);
    localparam logic [HW-1:0] H_LAST_C  = HW'(H_COUNT_MAX - 1);
    localparam logic [HW-1:0] H_START_C = HW'(H_START);
    localparam logic [HW-1:0] H_END_C   = HW'(H_START + H_ACTIVE);
    localparam logic [VW-1:0] V_MAX_C   = VW'(V_COUNT_MAX);
    localparam logic [VW-1:0] V_LAST_C  = VW'(V_COUNT_MAX - 1);
    localparam logic [VW-1:0] V_START_C = VW'(V_START);
    localparam logic [VW-1:0] V_END_C   = VW'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, SYNCING, LOCKED} state_t;

    state_t                  state_q;
    logic                    err_seen_q, locked_q;
    logic                    hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [PIXEL_BITS-1:0]   r_q, g_q, b_q;
    logic [DW-1:0]           div_q, div_d, div_eff;
    logic [HW-1:0]           h_cnt_q, h_cnt_d;
    logic [VW-1:0]           v_cnt_q, v_cnt_d;
    logic                    vs_pend_q, vs_pend_d;
    logic                    hs_fall, vs_fall, tick, v_clear, err_now, active;
    logic                    pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic                    line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic [XW-1:0]           pix_x_q, pix_x_d;
    logic [YW-1:0]           pix_y_q, pix_y_d;
    logic [3*PIXEL_BITS-1:0] pix_data_q, pix_data_d;

    always_comb begin
        hs_fall = hs_prev_q & ~hs_q;
        vs_fall = vs_prev_q & ~vs_q;
        // An hsync fall re-phases the divider so its own cycle is a tick.
        div_eff = hs_fall ? '0 : div_q;
        tick    = (div_eff == '0);
        div_d   = (div_eff == DIV_LAST) ? '0 : div_eff + DW'(1);

        h_cnt_d    = h_cnt_q;
        line_err_d = 1'b0;
        if (hs_fall) begin
            h_cnt_d    = '0;
            line_err_d = (h_cnt_q != H_LAST_C) && (h_cnt_q != H_MAX_C);
        end else if (tick && h_cnt_q == H_LAST_C) begin
            h_cnt_d    = H_MAX_C;
            line_err_d = 1'b1;
        end else if (tick && h_cnt_q != H_MAX_C) begin
            h_cnt_d = h_cnt_q + HW'(1);
        end

        vs_pend_d = vs_pend_q | vs_fall;
        v_cnt_d   = v_cnt_q;
        v_clear   = 1'b0;
        if (hs_fall) begin
            if (vs_pend_q || vs_fall) begin
                v_cnt_d   = '0;
                vs_pend_d = 1'b0;
                v_clear   = 1'b1;
            end else if (v_cnt_q != V_MAX_C) begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end

        frame_err_d = v_clear && (state_q != SEARCH) && (v_cnt_q != V_LAST_C);
        err_now     = line_err_d | frame_err_d;

        // Coordinates of this tick are the post-update counter values.
        active = tick && (state_q == LOCKED)
              && (h_cnt_d >= H_START_C) && (h_cnt_d < H_END_C)
              && (v_cnt_d >= V_START_C) && (v_cnt_d < V_END_C);
        pix_valid_d   = active;
        pix_x_d       = active ? XW'(h_cnt_d - H_START_C) : pix_x_q;
        pix_y_d       = active ? YW'(v_cnt_d - V_START_C) : pix_y_q;
        pix_data_d    = active ? {r_q, g_q, b_q} : pix_data_q;
        frame_start_d = active && (h_cnt_d == H_START_C) && (v_cnt_d == V_START_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vs_pend_q     <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
        end else begin
            hs_q          <= h_sync;
            vs_q          <= v_sync;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            r_q           <= vga_r;
            g_q           <= vga_g;
            b_q           <= vga_b;
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_pend_q     <= vs_pend_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEARCH;
            err_seen_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (v_clear) state_q <= SYNCING;
                    err_seen_q <= 1'b0;
                end
                SYNCING: begin
                    // A clean frame promotes to LOCKED; otherwise the frame check restarts.
                    if (v_clear && !(err_seen_q || err_now)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end
                    err_seen_q <= v_clear ? 1'b0 : (err_seen_q | err_now);
                end
                LOCKED: begin
                    if (err_now) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign locked      = locked_q;
endmodule
